// File: rtl/sram_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
// The pipeline is the master; the controller answers on read_data and ready.
interface sram_ctrl_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output wr_en, rd_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  wr_en, rd_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit load/store into two 16-bit SRAM accesses (low half, then high half),
// each held WAIT_CYCLES+1 cycles, and freezes the pipeline until the word is done.
module sram_ctrl #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   sram_ctrl_if.slave  bus,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_t      state_r, state_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        op_wr_r, op_wr_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic [31:0] rdata_r;
   logic        last_s, ready_s, cap_lo_s, cap_hi_s;
   logic [16:0] offset_s;
   logic [17:0] sram_addr_s, sram_addr_r;
   logic [15:0] dq_out_s, dq_out_r;
   logic        dq_oe_s, dq_oe_r, we_n_s, we_n_r;

   // Next-state, request latching and read-capture strobes.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      op_wr_s  = op_wr_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      ready_s  = 1'b0;
      cap_lo_s = 1'b0;
      cap_hi_s = 1'b0;
      last_s   = (cnt_r == WAIT_LAST);
      case (state_r)
         IDLE: begin
            if (bus.rd_en || bus.wr_en) begin
               state_s = LOW;
               cnt_s   = 4'd0;
               op_wr_s = bus.wr_en;
               addr_s  = bus.address;
               wdata_s = bus.write_data;
            end else begin
               ready_s = 1'b1;
            end
         end
         LOW: begin
            if (last_s) begin
               state_s  = HIGH;
               cnt_s    = 4'd0;
               cap_lo_s = ~op_wr_r;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         HIGH: begin
            if (last_s) begin
               state_s  = DONE;
               cnt_s    = 4'd0;
               cap_hi_s = ~op_wr_r;
            end else begin
               cnt_s = cnt_r + 4'd1;
            end
         end
         DONE: begin
            ready_s = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // SRAM pin values for the upcoming cycle, so the pins come straight from flops.
   always_comb begin
      offset_s    = 17'((addr_s - BASE_ADDR) >> 2);
      sram_addr_s = 18'd0;
      dq_out_s    = 16'd0;
      dq_oe_s     = 1'b0;
      we_n_s      = 1'b1;
      case (state_s)
         LOW: begin
            sram_addr_s = {offset_s, 1'b0};
            if (op_wr_s) begin
               dq_out_s = wdata_s[15:0];
               dq_oe_s  = 1'b1;
               we_n_s   = 1'b0;
            end else begin
               dq_out_s = 16'd0;
            end
         end
         HIGH: begin
            sram_addr_s = {offset_s, 1'b1};
            if (op_wr_s) begin
               dq_out_s = wdata_s[31:16];
               dq_oe_s  = 1'b1;
               we_n_s   = 1'b0;
            end else begin
               dq_out_s = 16'd0;
            end
         end
         default: begin
            sram_addr_s = 18'd0;
         end
      endcase
   end

   // Control state, latched request and registered SRAM pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         op_wr_r     <= 1'b0;
         addr_r      <= 32'd0;
         wdata_r     <= 32'd0;
         sram_addr_r <= 18'd0;
         dq_out_r    <= 16'd0;
         dq_oe_r     <= 1'b0;
         we_n_r      <= 1'b1;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         op_wr_r     <= op_wr_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         sram_addr_r <= sram_addr_s;
         dq_out_r    <= dq_out_s;
         dq_oe_r     <= dq_oe_s;
         we_n_r      <= we_n_s;
      end
   end

   // Load result assembled half by half; untouched by writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r <= 32'd0;
      end else if (cap_lo_s) begin
         rdata_r[15:0] <= sram_dq_in;
      end else if (cap_hi_s) begin
         rdata_r[31:16] <= sram_dq_in;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign bus.ready     = ready_s;
   assign bus.read_data = rdata_r;
   assign sram_addr     = sram_addr_r;
   assign sram_dq_out   = dq_out_r;
   assign sram_dq_oe    = dq_oe_r;
   assign sram_we_n     = we_n_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed scenarios plus randomized loads/stores,
// checked cycle by cycle against a word-level memory model and a timing schedule.
module tb_sram_ctrl;
   localparam int          WAIT_CYCLES = 2;
   localparam int          N           = WAIT_CYCLES + 1;
   localparam logic [31:0] BASE_ADDR   = 32'd1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;

   sram_ctrl_if bus ();

   sram_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .BASE_ADDR(BASE_ADDR)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   always #5 clk = ~clk;

   // Asynchronous-read SRAM device, written on the clock edge while we_n is low.
   bit [15:0] sram_mem [262144];
   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
   end
   assign sram_dq_in = sram_mem[sram_addr];

   // Word-level reference: what a load of each data-memory word should return.
   bit [31:0]   ref_words [131072];
   logic [31:0] exp_rdata;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE_ADDR;
      return int'((d / 32'd4) % 32'd131072);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.wr_en      = 1'b0;
      bus.rd_en      = 1'b0;
      bus.address    = $urandom;
      bus.write_data = $urandom;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         drive_idle();
         @(negedge clk);
         chk("idle_ready", 32'(bus.ready), 32'd1);
         chk("idle_we_n", 32'(sram_we_n), 32'd1);
         chk("idle_addr", 32'(sram_addr), 32'd0);
      end
   endtask

   // One transaction; cycle 0 is the request cycle. abort_at >= 0 pulses rst in that cycle.
   task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input int abort_at);
      int          w;
      logic [17:0] a_lo;
      logic        in_lo, in_hi, is_wr;
      logic [15:0] exp_dq;
      logic [17:0] exp_addr;
      w     = word_of(addr);
      a_lo  = 18'(w * 2);
      is_wr = wr;
      for (int c = 0; c <= 2 * N + 1; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            bus.wr_en      = wr;
            bus.rd_en      = rd;
            bus.address    = addr;
            bus.write_data = data;
         end else if (c <= 2 * N) begin
            bus.wr_en      = 1'($urandom);
            bus.rd_en      = 1'($urandom);
            bus.address    = $urandom;
            bus.write_data = $urandom;
         end else begin
            drive_idle();
         end
         in_lo = (c >= 1) && (c <= N);
         in_hi = (c > N) && (c <= 2 * N);
         if (c == abort_at) begin
            chk("pre_abort_we_n", 32'(sram_we_n), 32'(!(is_wr && (in_lo || in_hi))));
            rst = 1'b1;
            #1;
            chk("abort_we_n", 32'(sram_we_n), 32'd1);
            chk("abort_oe", 32'(sram_dq_oe), 32'd0);
            chk("abort_addr", 32'(sram_addr), 32'd0);
            chk("abort_dq", 32'(sram_dq_out), 32'd0);
            exp_rdata = 32'd0;
            chk("abort_rdata", bus.read_data, exp_rdata);
            if (is_wr && abort_at >= 2) ref_words[w][15:0] = data[15:0];
            if (is_wr && abort_at >= N + 2) ref_words[w][31:16] = data[31:16];
            drive_idle();
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         exp_addr = in_lo ? a_lo : (in_hi ? (a_lo | 18'd1) : 18'd0);
         exp_dq   = (is_wr && in_lo) ? data[15:0] : ((is_wr && in_hi) ? data[31:16] : 16'd0);
         chk($sformatf("ready_c%0d", c), 32'(bus.ready), 32'(c == 2 * N + 1));
         chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(exp_addr));
         chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!(is_wr && (in_lo || in_hi))));
         chk($sformatf("oe_c%0d", c), 32'(sram_dq_oe), 32'(is_wr && (in_lo || in_hi)));
         chk($sformatf("dq_c%0d", c), 32'(sram_dq_out), 32'(exp_dq));
         if (c == 2 * N + 1) begin
            if (!is_wr) exp_rdata = ref_words[w];
            chk("read_data", bus.read_data, exp_rdata);
         end
      end
      if (is_wr) ref_words[w] = data;
   endtask

   initial begin
      int          op, sel, gap;
      logic [31:0] a;
      drive_idle();
      exp_rdata = 32'd0;
      #1 rst = 1'b1;
      #1;
      chk("rst_rdata", bus.read_data, 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_cycles(2);

      do_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1);
      idle_cycles(1);
      do_txn(1'b0, 1'b1, 32'd1024, 32'h0, -1);
      do_txn(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, -1);
      idle_cycles(1);
      do_txn(1'b0, 1'b1, 32'd1024, 32'h0, -1);
      do_txn(1'b0, 1'b1, 32'd1028, 32'h0, -1);
      idle_cycles(1);
      do_txn(1'b1, 1'b0, 32'd1032, 32'h12345678, N + 1);
      idle_cycles(2);
      do_txn(1'b0, 1'b1, 32'd1032, 32'h0, -1);

      for (int t = 0; t < 40; t++) begin
         op  = int'($urandom_range(0, 2));
         sel = int'($urandom_range(0, 9));
         if (sel < 8) a = BASE_ADDR + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
         else if (sel == 8) a = BASE_ADDR - ($urandom_range(1, 3) << 2);
         else a = $urandom;
         do_txn(op != 0, op != 1, a, $urandom, -1);
         gap = int'($urandom_range(0, 2));
         idle_cycles(gap);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra cycles each 16-bit SRAM half-access is held (access length N = WAIT_CYCLES+1).
REQ-002 Parameter BASE_ADDR, default 1024, byte address of data-memory word 0.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  store request from MEM stage.
REQ-006 rd_en  in  1  load request from MEM stage.
REQ-007 address  in  32  byte address (ALU result).
REQ-008 write_data  in  32  store value.
REQ-009 read_data  out  32  registered load result.
REQ-010 ready  out  1  0 = freeze pipeline; 1 = request complete or no request.
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_dq_out  out  16  SRAM write data.
REQ-013 sram_dq_in  in  16  SRAM read data.
REQ-014 sram_dq_oe  out  1  1 = controller drives the SRAM data bus.
REQ-015 sram_we_n  out  1  active-low SRAM write strobe.

Function
REQ-016 FSM states IDLE, LOW, HIGH, DONE; a wait counter of at least 4 bits counts cycles within LOW and HIGH.
REQ-017 IDLE with rd_en|wr_en: ready=0; latch op, address and write_data; next state LOW with the counter cleared.
REQ-018 IDLE with no request: ready=1 (combinational); remain in IDLE.
REQ-019 LOW lasts exactly N cycles, then HIGH lasts exactly N cycles, then DONE lasts 1 cycle, then IDLE.
REQ-020 ready is 0 in LOW and HIGH, and 1 in DONE.
REQ-021 Total latency: request first seen at IDLE cycle 0; ready=1 only in cycle 2N+1.
REQ-022 Word offset = (latched address - BASE_ADDR) mod 2^32, bits [18:2].
REQ-023 sram_addr = {offset, 0} in LOW and {offset, 1} in HIGH.
REQ-024 In IDLE and DONE, sram_addr = 0.
REQ-025 Write in LOW: sram_dq_oe=1, sram_dq_out=write_data[15:0], sram_we_n=0.
REQ-026 Write in HIGH: sram_dq_oe=1, sram_dq_out=write_data[31:16], sram_we_n=0.
REQ-027 Otherwise: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-028 Read: on the last LOW cycle, capture sram_dq_in into read_data[15:0].
REQ-029 Read: on the last HIGH cycle, capture sram_dq_in into read_data[31:16].
REQ-030 read_data holds its value until the next read overwrites it; writes leave read_data unchanged.
REQ-031 rd_en and wr_en asserted together: the request is treated as a write.
REQ-032 Request inputs are ignored outside IDLE; a transaction, once started, always completes even if its request is dropped.
REQ-033 Back-to-back: a request present in the IDLE cycle after DONE starts a new transaction with no idle gap.
REQ-034 Address bits [1:0] are ignored; no range check is performed and addresses wrap modulo 2^17 words.

Reset
REQ-035 While rst=1, regardless of clk: state=IDLE, counter=0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-036 rst asserted mid-transaction aborts the transaction immediately; no further SRAM strobes are driven.
REQ-037 After rst release, ready=1 if no request is present.

Verification (WAIT_CYCLES=2, N=3, cycle 0 = first request cycle)
REQ-038 Reset: assert rst with no clock edge -> read_data=0, sram_we_n=1, sram_dq_oe=0, ready=1 when no request is present.
REQ-039 Write address 1024, data 0xDEADBEEF -> cycles 1-3: sram_addr=0, dq_out=0xBEEF, we_n=0; cycles 4-6: sram_addr=1, dq_out=0xDEAD; cycle 7: ready=1.
REQ-040 Read address 1024 with SRAM model from REQ-039 -> ready=0 for cycles 0-6; cycle 7: ready=1, read_data=0xDEADBEEF.
REQ-041 Write address 1028 with rd_en=1 as well -> treated as write: sram_addr 2 then 3; read_data unchanged.
REQ-042 rst pulse in cycle 4 of a write -> we_n=1 and sram_dq_oe=0 immediately; after release with no request, ready=1 and state=IDLE.
REQ-043 Two reads held back-to-back -> second transaction enters LOW in cycle 9; its ready=1 in cycle 15.
